// File: rtl/dsm_pkg.sv
// Shared types and scale helpers for the delta-sigma DAC core.
package dsm_pkg;

  typedef enum logic {DSM_IDLE, DSM_RUN} dsm_state_e;
  typedef enum logic {DSM_ORD1, DSM_ORD2} dsm_order_e;

  function automatic int unsigned dsm_fs(input int unsigned w);
    return 32'd1 << w;
  endfunction

  function automatic int unsigned dsm_half(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  // Second-order input range kept inside [FS/8, 7FS/8] for loop stability.
  function automatic int unsigned dsm_clamp_lo(input int unsigned w);
    return dsm_fs(w) / 8;
  endfunction

  function automatic int unsigned dsm_clamp_hi(input int unsigned w);
    return (7 * dsm_fs(w)) / 8;
  endfunction

endpackage

// File: rtl/dsm_sat_integrator.sv
// Combinational saturating acc + a - b with overflow flag.
module dsm_sat_integrator #(
  parameter int unsigned INT_WIDTH = 12
) (
  input  logic signed [INT_WIDTH-1:0] acc_i,
  input  logic signed [INT_WIDTH-1:0] a_i,
  input  logic signed [INT_WIDTH-1:0] b_i,
  output logic signed [INT_WIDTH-1:0] sum_o,
  output logic                        ovf_o
);

  localparam int unsigned EW = INT_WIDTH + 2;

  logic signed [EW-1:0] full;
  logic [EW-INT_WIDTH:0] top;

  assign full = EW'(acc_i) + EW'(a_i) - EW'(b_i);
  assign top  = full[EW-1:INT_WIDTH-1];

  always_comb begin
    ovf_o = !((&top) || (~|top));
    sum_o = full[INT_WIDTH-1:0];
    if (ovf_o) begin
      sum_o = full[EW-1] ? {1'b1, {(INT_WIDTH-1){1'b0}}}
                         : {1'b0, {(INT_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/dsm2_stream_module.sv
// Delta-sigma DAC with selectable 1st/2nd-order shaping and a per-sample handshake.
module dsm2_stream_module
  import dsm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OSR        = 4,
  parameter int unsigned INT_WIDTH  = DATA_WIDTH + 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  order_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  data_o,
  output logic                  underrun_o,
  output logic                  sat_o
);

  localparam int unsigned CNT_W = (OSR > 2) ? $clog2(OSR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);
  localparam logic signed [INT_WIDTH-1:0] FS_S   = $signed(INT_WIDTH'(dsm_fs(DATA_WIDTH)));
  localparam logic signed [INT_WIDTH-1:0] HALF_S = $signed(INT_WIDTH'(dsm_half(DATA_WIDTH)));
  localparam logic [DATA_WIDTH-1:0] CLAMP_LO = DATA_WIDTH'(dsm_clamp_lo(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] CLAMP_HI = DATA_WIDTH'(dsm_clamp_hi(DATA_WIDTH));

  dsm_state_e state_q, state_d;
  dsm_order_e order_q, order_d, order_eff;
  logic [DATA_WIDTH-1:0] sample_q, sample_d, sample_in;
  logic [CNT_W-1:0] osr_cnt_q, osr_cnt_d;
  logic signed [INT_WIDTH-1:0] e1_q, e1_d, e2_q, e2_d, e1_n, e2_n, x, fb;
  logic data_q, data_d, underrun_q, underrun_d, sat_q, sat_d;
  logic ovf1, ovf2, period_end, accept, clamp, y;

  assign period_end = (osr_cnt_q == CNT_LAST);
  assign ready_o    = en_i && ((state_q == DSM_IDLE) || period_end);
  assign accept     = ready_o && valid_i;
  assign order_eff  = (state_q == DSM_IDLE) ? dsm_order_e'(order_i) : order_q;

  always_comb begin
    sample_in = data_i;
    clamp     = 1'b0;
    if (order_eff == DSM_ORD2) begin
      if (data_i < CLAMP_LO) begin
        sample_in = CLAMP_LO;
        clamp     = 1'b1;
      end else if (data_i > CLAMP_HI) begin
        sample_in = CLAMP_HI;
        clamp     = 1'b1;
      end
    end
  end

  assign x  = $signed(INT_WIDTH'(sample_q));
  assign fb = data_q ? FS_S : '0;

  dsm_sat_integrator #(.INT_WIDTH(INT_WIDTH)) u_int1 (
    .acc_i(e1_q), .a_i(x), .b_i(fb), .sum_o(e1_n), .ovf_o(ovf1)
  );

  dsm_sat_integrator #(.INT_WIDTH(INT_WIDTH)) u_int2 (
    .acc_i(e2_q), .a_i(e1_n), .b_i(fb), .sum_o(e2_n), .ovf_o(ovf2)
  );

  assign y = (order_q == DSM_ORD2) ? (e2_n >= HALF_S) : (e1_n >= HALF_S);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= DSM_IDLE;
      order_q    <= DSM_ORD1;
      sample_q   <= '0;
      osr_cnt_q  <= '0;
      e1_q       <= '0;
      e2_q       <= '0;
      data_q     <= 1'b0;
      underrun_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      order_q    <= order_d;
      sample_q   <= sample_d;
      osr_cnt_q  <= osr_cnt_d;
      e1_q       <= e1_d;
      e2_q       <= e2_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
      sat_q      <= sat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DSM_IDLE: if (accept) state_d = DSM_RUN;
      DSM_RUN:  if (!en_i)  state_d = DSM_IDLE;
      default:  state_d = DSM_IDLE;
    endcase
  end

  always_comb begin
    order_d    = order_q;
    sample_d   = sample_q;
    osr_cnt_d  = osr_cnt_q;
    e1_d       = e1_q;
    e2_d       = e2_q;
    data_d     = data_q;
    underrun_d = 1'b0;
    sat_d      = 1'b0;
    if (state_q == DSM_IDLE || !en_i) begin
      e1_d      = '0;
      e2_d      = '0;
      data_d    = 1'b0;
      osr_cnt_d = '0;
      if (state_q == DSM_IDLE && accept) begin
        sample_d = sample_in;
        order_d  = dsm_order_e'(order_i);
        sat_d    = clamp;
      end
    end else begin
      // The edge that accepts a new sample still modulates the old one.
      e1_d   = e1_n;
      e2_d   = (order_q == DSM_ORD2) ? e2_n : '0;
      data_d = y;
      sat_d  = ovf1 || ((order_q == DSM_ORD2) && ovf2);
      if (period_end) begin
        osr_cnt_d = '0;
        if (accept) begin
          sample_d = sample_in;
          sat_d    = sat_d || clamp;
        end else begin
          underrun_d = 1'b1;
        end
      end else begin
        osr_cnt_d = osr_cnt_q + 1'b1;
      end
    end
  end

  assign data_o     = data_q;
  assign underrun_o = underrun_q;
  assign sat_o      = sat_q;

endmodule

// File: tb/tb_dsm2_stream_module.sv
// Directed-vector bench for dsm2_stream_module (W=8, OSR=4).
module tb_dsm2_stream_module;

  logic clk = 1'b0;
  logic rst_n, en, order, valid;
  logic [7:0] din;
  logic ready, dout, underrun, sat;
  int checks = 0;
  int errors = 0;

  dsm2_stream_module #(.DATA_WIDTH(8), .OSR(4), .INT_WIDTH(12)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .order_i(order), .data_i(din),
    .valid_i(valid), .ready_o(ready), .data_o(dout), .underrun_o(underrun),
    .sat_o(sat)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic go_idle;
    en = 1'b0; valid = 1'b0;
    tick();
  endtask

  task automatic start_run(input logic o, input logic [7:0] d);
    en = 1'b1; valid = 1'b1; order = o; din = d;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; valid = 1'b1; order = 1'b0; din = 8'h55;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dout !== 1'b0) begin errors++; $display("FAIL reset_data_o got %b expected 0", dout); end
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b expected 0", underrun); end
    checks++;
    if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %b expected 0", sat); end
    rst_n = 1'b1; en = 1'b0; valid = 1'b0;
    tick();
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL idle_disabled_ready got %b expected 0", ready); end
    en = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL idle_enabled_ready got %b expected 1", ready); end
  endtask

  task automatic test_order0_half;
    go_idle();
    start_run(1'b0, 8'h80);
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (dout !== (i % 2 == 0)) begin errors++; $display("FAIL o0_half_data[%0d] got %b expected %b", i, dout, (i % 2 == 0)); end
      checks++;
      if (ready !== (i % 4 == 2)) begin errors++; $display("FAIL o0_half_ready[%0d] got %b expected %b", i, ready, (i % 4 == 2)); end
      checks++;
      if (underrun !== 1'b0) begin errors++; $display("FAIL o0_half_underrun[%0d] got %b expected 0", i, underrun); end
    end
  endtask

  task automatic test_order0_levels;
    int ones;
    go_idle();
    start_run(1'b0, 8'h40);
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (dout !== (i % 4 == 1)) begin errors++; $display("FAIL o0_quarter_data[%0d] got %b expected %b", i, dout, (i % 4 == 1)); end
    end
    go_idle();
    start_run(1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (dout !== 1'b0) begin errors++; $display("FAIL o0_zero_data[%0d] got %b expected 0", i, dout); end
    end
    go_idle();
    start_run(1'b0, 8'hFF);
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (dout === 1'b1) ones++;
    end
    checks++;
    if (ones < 254 || ones > 256) begin errors++; $display("FAIL o0_full_ones got %0d expected 255+/-1", ones); end
  endtask

  task automatic test_order1;
    int ones, bad, sats;
    logic acc;
    go_idle();
    start_run(1'b1, 8'h00);
    checks++;
    if (sat !== 1'b1) begin errors++; $display("FAIL o1_clamp_first_sat got %b expected 1", sat); end
    ones = 0; bad = 0;
    for (int i = 0; i < 1024; i++) begin
      acc = ready & valid;
      tick();
      if (dout === 1'b1) ones++;
      if (sat !== acc) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL o1_clamp_sat_per_accept got %0d mismatched cycles expected 0", bad); end
    checks++;
    if (ones < 126 || ones > 130) begin errors++; $display("FAIL o1_clamp_ones got %0d expected 128+/-2", ones); end
    go_idle();
    start_run(1'b1, 8'h80);
    checks++;
    if (sat !== 1'b0) begin errors++; $display("FAIL o1_mid_first_sat got %b expected 0", sat); end
    ones = 0; sats = 0;
    for (int i = 0; i < 1024; i++) begin
      tick();
      if (dout === 1'b1) ones++;
      if (sat === 1'b1) sats++;
    end
    checks++;
    if (ones < 510 || ones > 514) begin errors++; $display("FAIL o1_mid_ones got %0d expected 512+/-2", ones); end
    checks++;
    if (sats != 0) begin errors++; $display("FAIL o1_mid_sat_count got %0d expected 0", sats); end
  endtask

  task automatic test_underrun;
    go_idle();
    start_run(1'b0, 8'h40);
    valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (underrun !== (i % 4 == 3)) begin errors++; $display("FAIL underrun_pulse[%0d] got %b expected %b", i, underrun, (i % 4 == 3)); end
      checks++;
      if (dout !== (i % 4 == 1)) begin errors++; $display("FAIL underrun_data[%0d] got %b expected %b", i, dout, (i % 4 == 1)); end
    end
    valid = 1'b1; din = 8'h40;
    for (int i = 16; i < 24; i++) begin
      tick();
      checks++;
      if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_resume[%0d] got %b expected 0", i, underrun); end
      checks++;
      if (dout !== (i % 4 == 1)) begin errors++; $display("FAIL underrun_resume_data[%0d] got %b expected %b", i, dout, (i % 4 == 1)); end
    end
  endtask

  task automatic test_abort;
    for (int pass = 0; pass < 2; pass++) begin
      go_idle();
      rst_n = 1'b1;
      start_run(1'b0, 8'h80);
      repeat (2) tick();
      if (pass == 0) en = 1'b0;
      else rst_n = 1'b0;
      tick();
      checks++;
      if (dout !== 1'b0) begin errors++; $display("FAIL abort%0d_data got %b expected 0", pass, dout); end
      checks++;
      if (underrun !== 1'b0) begin errors++; $display("FAIL abort%0d_underrun got %b expected 0", pass, underrun); end
      if (pass == 0) begin
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL abort0_ready got %b expected 0", ready); end
      end
      rst_n = 1'b1;
      start_run(1'b1, 8'h80);
      order = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tick();
        checks++;
        if (dout !== (i % 4 == 0 || i % 4 == 3)) begin
          errors++;
          $display("FAIL abort%0d_o1_data[%0d] got %b expected %b", pass, i, dout, (i % 4 == 0 || i % 4 == 3));
        end
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; order = 1'b0; valid = 1'b0; din = '0;
    @(negedge clk);
    test_reset();
    test_order0_half();
    test_order0_levels();
    test_order1();
    test_underrun();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
